usb_token_rx_ctrl: RTL

USB_TOKEN_RX_CTRL -- requirements
Module: usb_token_rx_ctrl

---
 rtl/usb_token_rx_ctrl_if.sv | 35 +++
 rtl/usb_token_rx_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/usb_token_rx_ctrl_if.sv
// Token receiver bus: PHY-side strobes toward the receiver and the decoded token / error results back.
// Optional TOKEN_ADDR_FILTER_EN adds the dev_addr field used for address filtering.
interface usb_token_rx_ctrl_if;
    logic       sop;
    logic       bit_valid;
    logic       bit_in;
    logic       eop;
    logic       abort;
`ifdef TOKEN_ADDR_FILTER_EN
    logic [6:0] dev_addr;
`endif
    logic       token_valid;
    logic [3:0] token_pid;
    logic [6:0] token_addr;
    logic [3:0] token_endp;
    logic       err_pulse;
    logic [1:0] err_code;
    logic       busy;

    modport master (
`ifdef TOKEN_ADDR_FILTER_EN
        output dev_addr,
`endif
        output sop, bit_valid, bit_in, eop, abort,
        input  token_valid, token_pid, token_addr, token_endp, err_pulse, err_code, busy
    );

    modport slave (
`ifdef TOKEN_ADDR_FILTER_EN
        input  dev_addr,
`endif
        input  sop, bit_valid, bit_in, eop, abort,
        output token_valid, token_pid, token_addr, token_endp, err_pulse, err_code, busy
    );
endinterface

// File: rtl/usb_token_rx_ctrl.sv
// USB token packet receiver: collects PID and 16 body bits from a de-stuffed bit stream,
// checks length, PID and CRC5, and reports either a decoded token or a reject reason.
// Optional macro TOKEN_ADDR_FILTER_EN: silently drops good tokens not addressed to dev_addr
// (address 0 is always accepted).
module usb_token_rx_ctrl (
    input logic              clk,
    input logic              n_rst,
    usb_token_rx_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PID, BODY, CHECK} state_t;

    localparam logic [4:0] CRC_INIT     = 5'b11111;
    localparam logic [4:0] CRC_RESIDUAL = 5'b01100;

    state_t      state, state_next;
    logic [4:0]  cnt, cnt_next;
    logic [4:0]  crc, crc_next;
    logic [7:0]  pid, pid_next;
    logic [15:0] body, body_next;
    logic        eop_take;
    logic [1:0]  verdict;
    logic        addr_ok;

    logic        token_valid;
    logic [3:0]  token_pid;
    logic [6:0]  token_addr;
    logic [3:0]  token_endp;
    logic        err_pulse;
    logic [1:0]  err_code;

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = b ^ c[4];
        return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    endfunction

    // State, bit counter and CRC register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
            crc   <= CRC_INIT;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            crc   <= crc_next;
        end
    end

    // PID and body shift registers; cleared at every packet start, so no reset needed
    always_ff @(posedge clk) begin
        pid  <= pid_next;
        body <= body_next;
    end

    // Next-state logic; abort beats sop, sop beats eop, eop beats a same-cycle data bit
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        crc_next   = crc;
        pid_next   = pid;
        body_next  = body;
        eop_take   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sop) begin
                    state_next = PID;
                    cnt_next   = 5'd0;
                    crc_next   = CRC_INIT;
                    pid_next   = 8'd0;
                    body_next  = 16'd0;
                end
            end
            PID, BODY: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (bus.sop) begin
                    state_next = PID;
                    cnt_next   = 5'd0;
                    crc_next   = CRC_INIT;
                    pid_next   = 8'd0;
                    body_next  = 16'd0;
                end else if (bus.eop) begin
                    state_next = CHECK;
                    eop_take   = 1'b1;
                end else if (bus.bit_valid) begin
                    if (state == PID) begin
                        pid_next = {bus.bit_in, pid[7:1]};
                        if (cnt == 5'd7) begin
                            state_next = BODY;
                            cnt_next   = 5'd0;
                        end else begin
                            cnt_next = cnt + 5'd1;
                        end
                    end else begin
                        body_next = {bus.bit_in, body[15:1]};
                        crc_next  = crc5_step(crc, bus.bit_in);
                        if (cnt != 5'd17) cnt_next = cnt + 5'd1;
                    end
                end
            end
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Packet verdict; an eop while still in PID always has a short count, so it lands on length
    always_comb begin
        verdict = 2'b00;
        if (state == PID || cnt != 5'd16)  verdict = 2'b11;
        else if (pid[7:4] != ~pid[3:0])    verdict = 2'b01;
        else if (pid[1:0] != 2'b01)        verdict = 2'b01;
        else if (crc != CRC_RESIDUAL)      verdict = 2'b10;
    end

`ifdef TOKEN_ADDR_FILTER_EN
    assign addr_ok = (body[6:0] == bus.dev_addr) || (body[6:0] == 7'h00);
`else
    assign addr_ok = 1'b1;
`endif

    // Result registers: pulses are high during the CHECK cycle, data loaded on the same edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            token_valid <= 1'b0;
            err_pulse   <= 1'b0;
            token_pid   <= 4'd0;
            token_addr  <= 7'd0;
            token_endp  <= 4'd0;
            err_code    <= 2'b00;
        end else begin
            token_valid <= eop_take && (verdict == 2'b00) && addr_ok;
            err_pulse   <= eop_take && (verdict != 2'b00);
            if (eop_take && verdict != 2'b00) err_code <= verdict;
            if (eop_take && verdict == 2'b00 && addr_ok) begin
                token_pid  <= pid[3:0];
                token_addr <= body[6:0];
                token_endp <= body[10:7];
            end
        end
    end

    assign bus.token_valid = token_valid;
    assign bus.token_pid   = token_pid;
    assign bus.token_addr  = token_addr;
    assign bus.token_endp  = token_endp;
    assign bus.err_pulse   = err_pulse;
    assign bus.err_code    = err_code;
    assign bus.busy        = (state != IDLE);
endmodule
